parity_strip_check: RTL and testbench
=====================================

// Module: parity_strip_check
// PURPOSE
//  Receive-side partner of the odd-parity generator. Takes the 9-bit stream
//  (bit[8] = odd parity over data[7:0]) plus sop/eop/vld, and checks each byte.
//  Strips the parity bit and forwards 8-bit data with 1-cycle latency.
//  Tracks packet framing, flags bad bytes and bad packets, and keeps saturating error counters.
// PARAMETERS
//  CNT_W   16   width of the byte_err_cnt and pkt_err_cnt counters
// PORTS
//  sys_clk       in   1      single clock; all logic on posedge
//  sys_rst       in   1      synchronous, active-high reset
//  in_sop        in   1      start of packet; qualified by in_vld
//  in_eop        in   1      end of packet; qualified by in_vld
//  in_vld        in   1      byte valid
//  in_data       in   9      [8] parity bit, [7:0] payload
//  cnt_clr       in   1      synchronous clear of both counters
//  out_sop       out  1      registered in_sop & in_vld & accepted
//  out_eop       out  1      registered in_eop & in_vld & accepted
//  out_vld       out  1      registered byte valid
//  out_data      out  8      payload with parity stripped
//  out_par_err   out  1      parity error on the current output byte; qualified by out_vld
//  pkt_err       out  1      1-cycle pulse with out_eop when the packet had >=1 bad byte
//  frm_err       out  1      1-cycle pulse on a framing violation (see below)
//  byte_err_cnt  out  CNT_W  saturating count of bad bytes
//  pkt_err_cnt   out  CNT_W  saturating count of bad or abandoned packets
// BEHAVIOUR
//  - Reset (sys_rst=1, including mid-packet):
//    - all outputs and counters are 0; FSM goes to IDLE; err_acc is 0.
//  - Parity rule: a byte is good iff ^in_data[8:0] == 1 (odd ones count over 9 bits).
//    - byte_bad = in_vld & ~^in_data.
//  - Latency is exactly 1 cycle for out_* relative to the accepted input.
//    - When out_vld=0, out_data holds its last value.
//    - When out_vld=0, out_sop, out_eop, out_par_err and pkt_err are 0.
//  - sop/eop with in_vld=0 are ignored entirely.
//  - FSM states: IDLE, IN_PKT.
//  - IDLE, vld&sop&~eop:
//    - forward the byte; go to IN_PKT; err_acc <= byte_bad.
//  - IDLE, vld&sop&eop (single-byte packet):
//    - forward the byte; stay in IDLE; pkt_err = byte_bad.
//  - IDLE, vld&~sop (orphan byte, with or without eop):
//    - byte dropped (out_vld=0); frm_err pulse; no counter changes.
//  - IN_PKT, vld&~sop&~eop:
//    - forward the byte; err_acc <= err_acc | byte_bad.
//  - IN_PKT, vld&eop&~sop:
//    - forward the byte; pkt_err = err_acc | byte_bad; go to IDLE; err_acc <= 0.
//  - IN_PKT, vld&sop (restart):
//    - frm_err pulse; the previous packet counts as bad (pkt_err_cnt +1, no pkt_err pulse).
//    - the new byte is handled exactly as in IDLE with the same sop/eop.
//  - Counters:
//    - byte_err_cnt += 1 for every forwarded byte with byte_bad.
//    - pkt_err_cnt += 1 on each pkt_err pulse and on each restart.
//    - A restart plus a bad single-byte packet in the same cycle adds +2 (saturating).
//    - Counters saturate at all-ones.
//    - cnt_clr has priority: it zeroes the counter and drops any increment from that cycle.
//  - Counters update in the same cycle as the matching out_* flags appear.
// STRUCTURE
//  - Package parity_pkg holds:
//    - state enum {IDLE, IN_PKT};
//    - localparam ODD_PARITY = 1'b1;
//    - default CNT_W.
//  - Sub-module sat_counter (#(W) clk, rst, clr, inc[1:0], q) is instantiated twice.
//  - Everything else (FSM, datapath registers) sits flat in this module.
// TESTING
//  1 Good packet: sop+0x00/p1, 0x03/p1, eop+0xFF/p1.
//    -> out_data 00,03,FF one cycle later; pkt_err=0; counters stay 0.
//  2 Bad byte mid-packet: 0x01 sent with p=1.
//    -> out_par_err=1 on that byte; pkt_err=1 with out_eop; byte_err_cnt=1; pkt_err_cnt=1.
//  3 Single-byte packet: sop&eop with 0x80/p0.
//    -> out_sop=out_eop=1 in the same cycle; pkt_err=0.
//    Repeat with p=1 -> pkt_err=1.
//  4 Framing: orphan byte in IDLE -> frm_err=1, out_vld=0.
//    sop,byte,sop,eop -> frm_err on the 2nd sop; pkt_err_cnt=1; second packet forwarded.
//  5 Saturation/clear: CNT_W=2 with 5 bad bytes -> byte_err_cnt=3.
//    cnt_clr together with a bad byte -> count is 0.
//  6 sys_rst asserted mid-packet -> all outputs 0 next cycle.
//    A following byte without sop is treated as an orphan (frm_err).

Source files
------------

// File: rtl/parity_pkg.sv
// Shared types and constants for the receive-side parity strip/check block.
package parity_pkg;

    // Packet framing state
    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    // A good 9-bit word carries an odd number of ones
    localparam logic ODD_PARITY = 1'b1;

    // Default width of the error counters
    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; adds 0..2 per cycle.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic [1:0]   inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX = '1;

    logic [W:0] sum_c;

    // One extra bit of headroom so an overflow past all-ones is visible
    always_comb begin
        sum_c = {1'b0, q} + (W+1)'(inc);
    end

    // Clear beats increment; otherwise clamp at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (sum_c > {1'b0, MAX}) begin
            q <= MAX;
        end else begin
            q <= sum_c[W-1:0];
        end
    end

endmodule

// File: rtl/parity_strip_check.sv
// Checks odd parity per byte, strips the parity bit, tracks packet framing
// and keeps saturating byte/packet error counters. One cycle of latency.
module parity_strip_check
    import parity_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             in_sop,
    input  logic             in_eop,
    input  logic             in_vld,
    input  logic [8:0]       in_data,
    input  logic             cnt_clr,
    output logic             out_sop,
    output logic             out_eop,
    output logic             out_vld,
    output logic [7:0]       out_data,
    output logic             out_par_err,
    output logic             pkt_err,
    output logic             frm_err,
    output logic [CNT_W-1:0] byte_err_cnt,
    output logic [CNT_W-1:0] pkt_err_cnt
);

    state_t state;
    logic   err_acc;

    logic       byte_bad_c;
    logic       sop_v_c;
    logic       restart_c;
    logic       orphan_c;
    logic       accept_c;
    logic       pkt_err_c;
    logic [1:0] byte_inc_c;
    logic [1:0] pkt_inc_c;

    // Per-cycle classification of the incoming byte
    always_comb begin
        byte_bad_c = in_vld & ((^in_data) != ODD_PARITY);
        sop_v_c    = in_vld & in_sop;
        restart_c  = sop_v_c & (state == IN_PKT);
        orphan_c   = in_vld & ~in_sop & (state == IDLE);
        accept_c   = sop_v_c | (in_vld & (state == IN_PKT));
        pkt_err_c  = 1'b0;
        if (sop_v_c) begin
            pkt_err_c = in_eop & byte_bad_c;
        end else if (in_vld & in_eop & (state == IN_PKT)) begin
            pkt_err_c = err_acc | byte_bad_c;
        end
        byte_inc_c = {1'b0, accept_c & byte_bad_c};
        // A restart abandons the open packet, which counts as bad on top
        // of any error on a single-byte packet arriving in the same cycle
        pkt_inc_c  = 2'(pkt_err_c) + 2'(restart_c);
    end

    // Framing FSM and registered output stage
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= IDLE;
            err_acc     <= 1'b0;
            out_sop     <= 1'b0;
            out_eop     <= 1'b0;
            out_vld     <= 1'b0;
            out_data    <= 8'h00;
            out_par_err <= 1'b0;
            pkt_err     <= 1'b0;
            frm_err     <= 1'b0;
        end else begin
            out_vld     <= accept_c;
            out_sop     <= sop_v_c;
            out_eop     <= accept_c & in_eop;
            out_par_err <= accept_c & byte_bad_c;
            pkt_err     <= pkt_err_c;
            frm_err     <= restart_c | orphan_c;
            if (accept_c) begin
                out_data <= in_data[7:0];
            end
            case (state)
                IDLE: begin
                    if (sop_v_c & ~in_eop) begin
                        state   <= IN_PKT;
                        err_acc <= byte_bad_c;
                    end
                end
                IN_PKT: begin
                    if (sop_v_c) begin
                        if (in_eop) begin
                            state   <= IDLE;
                            err_acc <= 1'b0;
                        end else begin
                            err_acc <= byte_bad_c;
                        end
                    end else if (in_vld & in_eop) begin
                        state   <= IDLE;
                        err_acc <= 1'b0;
                    end else if (in_vld) begin
                        err_acc <= err_acc | byte_bad_c;
                    end
                end
                default: begin
                    state   <= IDLE;
                    err_acc <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(.W(CNT_W)) u_byte_cnt (
        .clk (sys_clk),
        .rst (sys_rst),
        .clr (cnt_clr),
        .inc (byte_inc_c),
        .q   (byte_err_cnt)
    );

    sat_counter #(.W(CNT_W)) u_pkt_cnt (
        .clk (sys_clk),
        .rst (sys_rst),
        .clr (cnt_clr),
        .inc (pkt_inc_c),
        .q   (pkt_err_cnt)
    );

endmodule

// File: tb/tb_parity_strip_check.sv
// Bench for parity_strip_check: directed vector table, hand-written corner
// sequences and a randomized run against a packet-level reference model.
module tb_parity_strip_check;

    localparam int unsigned WIDE_W = 16;
    localparam int unsigned SAT_W  = 2;
    localparam int          WIDE_MAX = 65535;
    localparam int          SAT_MAX  = 3;

    logic        sys_clk = 1'b0;
    logic        sys_rst;
    logic        in_sop, in_eop, in_vld, cnt_clr;
    logic [8:0]  in_data;

    logic        a_sop, a_eop, a_vld, a_par, a_pkt, a_frm;
    logic [7:0]  a_data;
    logic [WIDE_W-1:0] a_bcnt, a_pcnt;

    logic        b_sop, b_eop, b_vld, b_par, b_pkt, b_frm;
    logic [7:0]  b_data;
    logic [SAT_W-1:0]  b_bcnt, b_pcnt;

    always #5 sys_clk = ~sys_clk;

    parity_strip_check dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_sop(in_sop), .in_eop(in_eop),
        .in_vld(in_vld), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_sop(a_sop), .out_eop(a_eop), .out_vld(a_vld), .out_data(a_data),
        .out_par_err(a_par), .pkt_err(a_pkt), .frm_err(a_frm),
        .byte_err_cnt(a_bcnt), .pkt_err_cnt(a_pcnt)
    );

    parity_strip_check #(.CNT_W(SAT_W)) dut_sat (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .in_sop(in_sop), .in_eop(in_eop),
        .in_vld(in_vld), .in_data(in_data), .cnt_clr(cnt_clr),
        .out_sop(b_sop), .out_eop(b_eop), .out_vld(b_vld), .out_data(b_data),
        .out_par_err(b_par), .pkt_err(b_pkt), .frm_err(b_frm),
        .byte_err_cnt(b_bcnt), .pkt_err_cnt(b_pcnt)
    );

    typedef struct {
        logic       rst, sop, eop, vld, clr;
        logic [8:0] data;
    } stim_t;

    typedef struct {
        logic       vld, sop, eop, par, pkt, frm;
        logic [7:0] data;
        int         bcnt, pcnt;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state (packet-level view)
    bit         m_in_pkt;
    bit         m_acc;
    exp_t       m_out;
    int         m_b_sat, m_p_sat;

    function automatic stim_t mk(input logic rst, input logic sop, input logic eop,
                                 input logic vld, input logic clr, input logic [8:0] data);
        stim_t s;
        s.rst = rst; s.sop = sop; s.eop = eop; s.vld = vld; s.clr = clr; s.data = data;
        return s;
    endfunction

    function automatic exp_t mke(input logic vld, input logic sop, input logic eop,
                                 input logic par, input logic pkt, input logic frm,
                                 input logic [7:0] data, input int bcnt, input int pcnt);
        exp_t e;
        e.vld = vld; e.sop = sop; e.eop = eop; e.par = par; e.pkt = pkt; e.frm = frm;
        e.data = data; e.bcnt = bcnt; e.pcnt = pcnt;
        return e;
    endfunction

    function automatic logic [13:0] pack_exp(input exp_t e);
        return {e.vld, e.sop, e.eop, e.par, e.pkt, e.frm, e.data};
    endfunction

    function automatic logic [13:0] act_wide();
        return {a_vld, a_sop, a_eop, a_par, a_pkt, a_frm, a_data};
    endfunction

    function automatic logic [13:0] act_sat();
        return {b_vld, b_sop, b_eop, b_par, b_pkt, b_frm, b_data};
    endfunction

    function automatic int clamp(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level reference: a byte is good when its 9 bits hold an odd count of ones
    task automatic model_step(input stim_t s);
        bit bad, fwd;
        int binc, pinc;
        m_out.vld = 0; m_out.sop = 0; m_out.eop = 0;
        m_out.par = 0; m_out.pkt = 0; m_out.frm = 0;
        if (s.rst) begin
            m_in_pkt = 0; m_acc = 0; m_out.data = 8'h00;
            m_out.bcnt = 0; m_out.pcnt = 0; m_b_sat = 0; m_p_sat = 0;
            return;
        end
        bad  = s.vld && ($countones(s.data) % 2 == 0);
        fwd  = 0;
        pinc = 0;
        if (s.vld) begin
            if (s.sop) begin
                if (m_in_pkt) begin
                    m_out.frm = 1;
                    pinc = 1;
                end
                fwd = 1;
                m_out.sop = 1;
                if (s.eop) begin
                    m_out.eop = 1; m_out.pkt = bad; m_in_pkt = 0; m_acc = 0;
                end else begin
                    m_in_pkt = 1; m_acc = bad;
                end
            end else if (!m_in_pkt) begin
                m_out.frm = 1;
            end else begin
                fwd = 1;
                if (s.eop) begin
                    m_out.eop = 1; m_out.pkt = m_acc || bad; m_in_pkt = 0; m_acc = 0;
                end else begin
                    m_acc = m_acc || bad;
                end
            end
        end
        if (fwd) begin
            m_out.vld = 1; m_out.data = s.data[7:0]; m_out.par = bad;
        end
        binc = (fwd && bad) ? 1 : 0;
        pinc += m_out.pkt ? 1 : 0;
        m_out.bcnt = s.clr ? 0 : clamp(m_out.bcnt + binc, WIDE_MAX);
        m_out.pcnt = s.clr ? 0 : clamp(m_out.pcnt + pinc, WIDE_MAX);
        m_b_sat    = s.clr ? 0 : clamp(m_b_sat + binc, SAT_MAX);
        m_p_sat    = s.clr ? 0 : clamp(m_p_sat + pinc, SAT_MAX);
    endtask

    // Apply one input cycle, sample one time unit after the edge, compare with the model
    task automatic cycle(input stim_t s);
        sys_rst = s.rst; in_sop = s.sop; in_eop = s.eop;
        in_vld  = s.vld; cnt_clr = s.clr; in_data = s.data;
        model_step(s);
        @(posedge sys_clk);
        #1;
        check("model_flags",     32'(act_wide()), 32'(pack_exp(m_out)));
        check("model_byte_cnt",  32'(a_bcnt), 32'(m_out.bcnt));
        check("model_pkt_cnt",   32'(a_pcnt), 32'(m_out.pcnt));
        check("model_sat_flags", 32'(act_sat()), 32'(pack_exp(m_out)));
        check("model_sat_bcnt",  32'(b_bcnt), 32'(m_b_sat));
        check("model_sat_pcnt",  32'(b_pcnt), 32'(m_p_sat));
    endtask

    vec_t vecs[16];

    initial begin
        sys_rst = 1'b1; in_sop = 1'b0; in_eop = 1'b0; in_vld = 1'b0;
        cnt_clr = 1'b0; in_data = 9'h000;

        //               rst sop eop vld clr data             vld sop eop par pkt frm data  b  p
        vecs[0]  = '{mk(1, 0, 0, 0, 0, 9'h000), mke(0, 0, 0, 0, 0, 0, 8'h00, 0, 0)};
        // good three-byte packet
        vecs[1]  = '{mk(0, 1, 0, 1, 0, 9'h100), mke(1, 1, 0, 0, 0, 0, 8'h00, 0, 0)};
        vecs[2]  = '{mk(0, 0, 0, 1, 0, 9'h103), mke(1, 0, 0, 0, 0, 0, 8'h03, 0, 0)};
        vecs[3]  = '{mk(0, 0, 1, 1, 0, 9'h1FF), mke(1, 0, 1, 0, 0, 0, 8'hFF, 0, 0)};
        // bad byte mid-packet
        vecs[4]  = '{mk(0, 1, 0, 1, 0, 9'h100), mke(1, 1, 0, 0, 0, 0, 8'h00, 0, 0)};
        vecs[5]  = '{mk(0, 0, 0, 1, 0, 9'h101), mke(1, 0, 0, 1, 0, 0, 8'h01, 1, 0)};
        vecs[6]  = '{mk(0, 0, 1, 1, 0, 9'h002), mke(1, 0, 1, 0, 1, 0, 8'h02, 1, 1)};
        // single-byte packets, good then bad
        vecs[7]  = '{mk(0, 1, 1, 1, 0, 9'h080), mke(1, 1, 1, 0, 0, 0, 8'h80, 1, 1)};
        vecs[8]  = '{mk(0, 1, 1, 1, 0, 9'h180), mke(1, 1, 1, 1, 1, 0, 8'h80, 2, 2)};
        // orphan byte in IDLE: dropped, data holds
        vecs[9]  = '{mk(0, 0, 0, 1, 0, 9'h100), mke(0, 0, 0, 0, 0, 1, 8'h80, 2, 2)};
        // sop, byte, restart sop, eop
        vecs[10] = '{mk(0, 1, 0, 1, 0, 9'h100), mke(1, 1, 0, 0, 0, 0, 8'h00, 2, 2)};
        vecs[11] = '{mk(0, 0, 0, 1, 0, 9'h100), mke(1, 0, 0, 0, 0, 0, 8'h00, 2, 2)};
        vecs[12] = '{mk(0, 1, 0, 1, 0, 9'h111), mke(1, 1, 0, 0, 0, 1, 8'h11, 2, 3)};
        vecs[13] = '{mk(0, 0, 1, 1, 0, 9'h122), mke(1, 0, 1, 0, 0, 0, 8'h22, 2, 3)};
        // sop/eop without vld ignored
        vecs[14] = '{mk(0, 1, 1, 0, 0, 9'h0AA), mke(0, 0, 0, 0, 0, 0, 8'h22, 2, 3)};
        // counter clear
        vecs[15] = '{mk(0, 0, 0, 0, 1, 9'h000), mke(0, 0, 0, 0, 0, 0, 8'h22, 0, 0)};

        @(negedge sys_clk);
        for (int i = 0; i < 16; i++) begin
            cycle(vecs[i].s);
            check($sformatf("vec%0d_flags", i), 32'(act_wide()), 32'(pack_exp(vecs[i].e)));
            check($sformatf("vec%0d_byte_cnt", i), 32'(a_bcnt), 32'(vecs[i].e.bcnt));
            check($sformatf("vec%0d_pkt_cnt", i), 32'(a_pcnt), 32'(vecs[i].e.pcnt));
        end

        // five bad bytes: narrow counter sticks at 3, wide one reaches 5
        cycle(mk(0, 1, 0, 1, 0, 9'h101));
        for (int i = 0; i < 3; i++) cycle(mk(0, 0, 0, 1, 0, 9'h101));
        cycle(mk(0, 0, 1, 1, 0, 9'h101));
        check("sat_byte_cnt",  32'(b_bcnt), 32'd3);
        check("wide_byte_cnt", 32'(a_bcnt), 32'd5);
        check("sat_pkt_cnt",   32'(b_pcnt), 32'd1);

        // clear wins over a bad single-byte packet in the same cycle
        cycle(mk(0, 1, 1, 1, 1, 9'h101));
        check("clr_byte_cnt", 32'(a_bcnt), 32'd0);
        check("clr_pkt_cnt",  32'(a_pcnt), 32'd0);
        check("clr_sat_cnt",  32'(b_bcnt), 32'd0);

        // restart together with a bad single-byte packet adds two
        cycle(mk(0, 1, 0, 1, 0, 9'h100));
        cycle(mk(0, 1, 1, 1, 0, 9'h101));
        check("restart_bad_pkt_cnt", 32'(a_pcnt), 32'd2);
        check("restart_bad_frm",     32'(a_frm),  32'd1);

        // reset mid-packet clears everything, next non-sop byte is an orphan
        cycle(mk(0, 1, 0, 1, 0, 9'h100));
        cycle(mk(1, 0, 0, 1, 0, 9'h105));
        check("rst_flags",    32'(act_wide()), 32'd0);
        check("rst_byte_cnt", 32'(a_bcnt), 32'd0);
        check("rst_pkt_cnt",  32'(a_pcnt), 32'd0);
        cycle(mk(0, 0, 0, 1, 0, 9'h100));
        check("post_rst_frm", 32'(a_frm), 32'd1);
        check("post_rst_vld", 32'(a_vld), 32'd0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            stim_t s;
            s.rst  = ($urandom_range(0, 199) == 0);
            s.clr  = ($urandom_range(0, 49) == 0);
            s.vld  = ($urandom_range(0, 3) != 0);
            s.sop  = ($urandom_range(0, 4) == 0);
            s.eop  = ($urandom_range(0, 3) == 0);
            s.data = 9'($urandom);
            cycle(s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
